// File: rtl/clock_div_scheduler.sv
// Runtime-programmable multi-channel 50%-duty clock divider with glitch-free ratio changes.
// Optional define CLOCK_DIV_SCHED_PHASE_ALIGN_EN: channels >0 start aligned to channel 0's period_tick.

module clock_div_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc,
  input  logic [CNT_W-1:0] cfg_half,
`ifdef CLOCK_DIV_SCHED_PHASE_ALIGN_EN
  input  logic             align_ok,
  output logic             free_tick,
`endif
  output logic             derived_clk,
  output logic             period_tick,
  output logic             active,
  output logic             pend_valid
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt, cur_half, pend_half;
  logic             last, start_ok;

  assign last   = (cnt == cur_half - CNT_W'(1));
  assign active = (state != IDLE);

`ifdef CLOCK_DIV_SCHED_PHASE_ALIGN_EN
  assign start_ok  = align_ok;
  // Boundary restart this edge; used by other channels to align their start.
  assign free_tick = (state == LOW) && last && !(pend_valid && pend_half == '0);
`else
  assign start_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_half    <= '0;
      pend_half   <= '0;
      pend_valid  <= 1'b0;
      derived_clk <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            if (pend_half == '0) begin
              pend_valid <= 1'b0;
            end else if (start_ok) begin
              state       <= HIGH;
              cur_half    <= pend_half;
              cnt         <= '0;
              derived_clk <= 1'b1;
              period_tick <= 1'b1;
              pend_valid  <= 1'b0;
            end
          end
        end
        HIGH: begin
          if (last) begin
            state       <= LOW;
            cnt         <= '0;
            derived_clk <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (last) begin
            cnt        <= '0;
            pend_valid <= 1'b0;
            if (pend_valid && pend_half == '0) begin
              state <= IDLE;
            end else begin
              state       <= HIGH;
              derived_clk <= 1'b1;
              period_tick <= 1'b1;
              if (pend_valid) cur_half <= pend_half;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Accept is only possible with no pending value, so it never races a consume.
      if (acc) begin
        pend_half  <= cfg_half;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

module clock_div_scheduler #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] derived_clk,
  output logic [NUM_CH-1:0] period_tick,
  output logic [NUM_CH-1:0] active
);
  localparam int NPAD = 1 << CH_W;

  logic [NUM_CH-1:0] pend_valid, acc;
  logic [NPAD-1:0]   pend_pad;
  logic              ch_ok;

  // Out-of-range channels read as not pending, so they are always ready and dropped.
  assign pend_pad  = NPAD'(pend_valid);
  assign cfg_ready = !pend_pad[cfg_ch];
  assign ch_ok     = (int'(cfg_ch) < NUM_CH);

`ifdef CLOCK_DIV_SCHED_PHASE_ALIGN_EN
  logic [NUM_CH-1:0] free_tick, align_ok;
  always_comb begin
    align_ok = '1;
    for (int i = 1; i < NUM_CH; i++) align_ok[i] = !active[0] || free_tick[0];
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign acc[i] = cfg_valid && cfg_ready && ch_ok && (cfg_ch == CH_W'(i));
    clock_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .acc         (acc[i]),
      .cfg_half    (cfg_half),
`ifdef CLOCK_DIV_SCHED_PHASE_ALIGN_EN
      .align_ok    (align_ok[i]),
      .free_tick   (free_tick[i]),
`endif
      .derived_clk (derived_clk[i]),
      .period_tick (period_tick[i]),
      .active      (active[i]),
      .pend_valid  (pend_valid[i])
    );
  end
endmodule

// File: doc/clock_div_scheduler.md
# clock_div_scheduler

Runtime-programmable multi-channel clock divider controller. Generates NUM_CH derived clocks from `clk`, each with a 50% duty cycle and a half-period programmed over a valid/ready configuration port. Ratio changes are applied only at period boundaries, so derived clocks never glitch. Drives the rate-derived clocks and enables for drone sensor sampling and motor update loops, and replaces fixed-ratio compile-time dividers where the rate must change at run time.

## Interface
- NUM_CH, 4, number of derived clock channels (1..16)
- CNT_W, 8, half-period counter width; the maximum half-period is 2^CNT_W-1
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden)

- clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration may be accepted; combinational, equals !pend_valid[cfg_ch]
- cfg_ch  in  CH_W  target channel
- cfg_half  in  CNT_W  new half-period in clk cycles; 0 stops the channel
- derived_clk  out  NUM_CH  derived clock per channel, registered
- period_tick  out  NUM_CH  one-cycle pulse, asserted in the same cycle derived_clk rises
- active  out  NUM_CH  channel state is not IDLE

## Operation
- Per-channel state: IDLE, HIGH, LOW, plus cnt[CNT_W], cur_half[CNT_W], pend_half[CNT_W], pend_valid.
- Accept condition: cfg_valid && cfg_ready. On accept, pend_half is set to cfg_half and pend_valid to 1.
- If cfg_ch >= NUM_CH: the request is dropped, cfg_ready is 1, and no state changes.
- IDLE with pend_valid:
  - If pend_half != 0: go to HIGH, set cur_half = pend_half, cnt = 0, derived_clk = 1, and pulse period_tick.
  - If pend_half == 0: stay IDLE.
  - Either way, clear pend_valid.
- HIGH:
  - Increment cnt each cycle.
  - When cnt == cur_half-1: go to LOW, set cnt = 0, derived_clk = 0.
- LOW:
  - Increment cnt each cycle.
  - When cnt == cur_half-1 (the boundary):
    - No pending: go to HIGH, cnt = 0, derived_clk = 1, pulse period_tick.
    - Pending nonzero: load cur_half = pend_half, then behave as the no-pending case.
    - Pending zero: go to IDLE with derived_clk kept at 0.
    - If a pending value was consumed, clear pend_valid.
- Pending updates never take effect mid-period. A channel never has more than one pending update, because cfg_ready is low while one is outstanding.
- Channels are independent and may be configured in any order.

## Timing
- Reset values: derived_clk = 0, period_tick = 0, active = 0, all channels IDLE, cnt = 0, cur_half = 0, pend_valid = 0. Therefore cfg_ready = 1.
- A running channel has period 2*cur_half cycles: exactly cur_half cycles high, then cur_half cycles low. With half = 1, derived_clk = clk/2.
- Start latency: for an accept at edge k on an IDLE channel, derived_clk rises at edge k+1.
- Change latency: a new value is applied at the first LOW-phase boundary after the accept edge. The old period always completes. If the accept lands on the boundary edge itself, the value is applied at the following boundary.
- Stop: derived_clk ends low after a full low phase. There is no truncated high pulse.
- cfg_ready for a channel returns high the cycle after its pending value is consumed.
- Reset asserted mid-operation: all outputs go low immediately (asynchronously) and pending requests are lost.
- Counter wrap: cnt never exceeds cur_half-1, so no overflow is possible. Writing the maximum value is legal.

## Configuration
- Macro: CLOCK_DIV_SCHED_PHASE_ALIGN_EN.
- Defined:
  - A channel other than 0 leaving IDLE does not start at edge k+1. It waits, pending, until the cycle in which channel 0 asserts period_tick, and starts on that same edge. Its rising edges are then phase-aligned to channel 0.
  - If channel 0 is IDLE, the channel starts immediately, as in the undefined case.
  - Channel 0 itself is unaffected.
- Undefined: every channel starts at edge k+1, with no alignment logic.

## Test plan
- Reset, then write ch0 half = 3 -> derived_clk[0] rises the edge after accept; pattern is 3 high / 3 low; period_tick[0] pulses every 6 cycles; active[0] = 1.
- ch1 running at half = 2, write half = 5 mid-high-phase -> the current 2/2 period completes, then 5/5 begins; cfg_ready is low for ch1 until the boundary; no pulse shorter than 2 cycles.
- ch2 running at half = 4, write half = 0 -> after the current low phase completes, derived_clk[2] stays 0, active[2] = 0, and no further ticks.
- Second write to ch1 while its pending is outstanding -> cfg_ready = 0 and the request is not accepted. A concurrent write to ch3 with half = 1 is accepted -> toggles every cycle.
- Assert reset while all channels run -> all outputs are 0 immediately. After release, writing half = 255 gives a 255/255 waveform with no counter wrap.
- CLOCK_DIV_SCHED_PHASE_ALIGN_EN defined, ch0 half = 4, then ch1 half = 2 -> every period_tick[0] pulse coincides with a period_tick[1] pulse.
